gcm_tag_sequencer: RTL

Controller that sequences the `ghash` engine to produce a full AES-GCM authentication tag.
- Loads the hash subkey H into `ghash`.
- Streams the AAD blocks, then the ciphertext blocks. The final partial block of each stream is zero-padded.
- Appends the 128-bit length block len(A)||len(C).
- XORs the GHASH result with E(K,J0) to emit the tag.
- Sits between the AES-CTR datapath / host stream and the `ghash` instance.

---
 rtl/gcm_tag_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/gcm_tag_sequencer.sv
// rtl/gcm_tag_sequencer.sv - sequences ghash over AAD, CT and the length block, then emits the GCM tag
// Optional build macro GCM_TAG_CHECK_EN adds exp_tag_i / tag_match_o.
module gcm_tag_sequencer #(
  parameter int LEN_W = 36
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_valid_i,
  input  logic [127:0] h_i,
  input  logic [127:0] ek0_i,
  input  logic         start_i,
  input  logic         has_aad_i,
  input  logic         has_ct_i,
  input  logic [127:0] aad_i,
  input  logic         aad_valid_i,
  output logic         aad_ready_o,
  input  logic         aad_last_i,
  input  logic [4:0]   aad_bytes_i,
  input  logic [127:0] ct_i,
  input  logic         ct_valid_i,
  output logic         ct_ready_o,
  input  logic         ct_last_i,
  input  logic [4:0]   ct_bytes_i,
`ifdef GCM_TAG_CHECK_EN
  input  logic [127:0] exp_tag_i,
  output logic         tag_match_o,
`endif
  output logic [127:0] gh_h_o,
  output logic         gh_h_valid_o,
  output logic [127:0] gh_din_o,
  output logic         gh_din_valid_o,
  input  logic         gh_din_ready_i,
  output logic         gh_last_o,
  input  logic [127:0] gh_dout_i,
  input  logic         gh_dout_valid_i,
  output logic [127:0] tag_o,
  output logic         tag_valid_o,
  output logic         busy_o
);

  typedef enum logic [2:0] {S_IDLE, S_AAD, S_CT, S_LEN, S_WAIT} state_t;

  state_t           state, state_nxt;
  logic             has_ct_q;
  logic [LEN_W-1:0] aad_cnt, ct_cnt;
  logic [127:0]     ek0_q;
  logic             gh_h_valid_q;
  logic [127:0]     s_data, masked;
  logic             s_last;
  logic [4:0]       s_bytes, n_bytes;
  logic             aad_xfer, ct_xfer, din_open;
  logic [63:0]      aad_bits, ct_bits;

  assign gh_h_valid_o = gh_h_valid_q;
  assign busy_o       = (state != S_IDLE);
  assign aad_bits     = 64'({aad_cnt, 3'b000});
  assign ct_bits      = 64'({ct_cnt, 3'b000});
  // Data is held off while H loads so ghash never sees a beat alongside h_valid.
  assign din_open     = !gh_h_valid_q;

  always_comb begin
    s_data  = (state == S_CT) ? ct_i       : aad_i;
    s_last  = (state == S_CT) ? ct_last_i  : aad_last_i;
    s_bytes = (state == S_CT) ? ct_bytes_i : aad_bytes_i;
    n_bytes = (s_last && s_bytes != 5'd0 && s_bytes <= 5'd16) ? s_bytes : 5'd16;
    masked  = s_data;
    for (int k = 0; k < 16; k++) begin
      if (5'(k) >= n_bytes) masked[127-8*k -: 8] = 8'h00;
    end
  end

  always_comb begin
    state_nxt      = state;
    aad_ready_o    = 1'b0;
    ct_ready_o     = 1'b0;
    gh_din_o       = '0;
    gh_din_valid_o = 1'b0;
    gh_last_o      = 1'b0;
    aad_xfer       = 1'b0;
    ct_xfer        = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_i) state_nxt = has_aad_i ? S_AAD : (has_ct_i ? S_CT : S_LEN);
      end
      S_AAD: begin
        gh_din_o       = masked;
        gh_din_valid_o = aad_valid_i && din_open;
        aad_ready_o    = gh_din_ready_i && din_open;
        aad_xfer       = aad_valid_i && aad_ready_o;
        if (aad_xfer && aad_last_i) state_nxt = has_ct_q ? S_CT : S_LEN;
      end
      S_CT: begin
        gh_din_o       = masked;
        gh_din_valid_o = ct_valid_i && din_open;
        ct_ready_o     = gh_din_ready_i && din_open;
        ct_xfer        = ct_valid_i && ct_ready_o;
        if (ct_xfer && ct_last_i) state_nxt = S_LEN;
      end
      S_LEN: begin
        gh_din_o       = {aad_bits, ct_bits};
        gh_din_valid_o = din_open;
        gh_last_o      = 1'b1;
        if (gh_din_ready_i && din_open) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (gh_dout_valid_i) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aad_cnt <= '0;
      ct_cnt  <= '0;
    end else if (state == S_IDLE && start_i) begin
      aad_cnt <= '0;
      ct_cnt  <= '0;
    end else begin
      if (aad_xfer) aad_cnt <= aad_cnt + LEN_W'(n_bytes);
      if (ct_xfer)  ct_cnt  <= ct_cnt + LEN_W'(n_bytes);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gh_h_o       <= '0;
      ek0_q        <= '0;
      gh_h_valid_q <= 1'b0;
      has_ct_q     <= 1'b0;
      tag_o        <= '0;
      tag_valid_o  <= 1'b0;
    end else begin
      gh_h_valid_q <= 1'b0;
      tag_valid_o  <= 1'b0;
      if (state == S_IDLE && cfg_valid_i) begin
        gh_h_o       <= h_i;
        ek0_q        <= ek0_i;
        gh_h_valid_q <= 1'b1;
      end
      if (state == S_IDLE && start_i) has_ct_q <= has_ct_i;
      if (state == S_WAIT && gh_dout_valid_i) begin
        tag_o       <= gh_dout_i ^ ek0_q;
        tag_valid_o <= 1'b1;
      end
    end
  end

`ifdef GCM_TAG_CHECK_EN
  logic [127:0] exp_tag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_tag_q   <= '0;
      tag_match_o <= 1'b0;
    end else begin
      tag_match_o <= 1'b0;
      if (state == S_IDLE && start_i) exp_tag_q <= exp_tag_i;
      if (state == S_WAIT && gh_dout_valid_i) tag_match_o <= ((gh_dout_i ^ ek0_q) == exp_tag_q);
    end
  end
`endif

endmodule
